proc_control_unit: RTL and testbench

- Moore FSM controller for the six-instruction processor.
- Drives the program counter (clear/increment) and the instruction register load.
- Decodes the 16-bit instruction and sequences data memory, register file and ALU controls.
- Sits between PC/instruction memory/IR and the datapath (RAM, register file, ALU).

---
 rtl/proc_ctrl_pkg.sv | 35 +++
 rtl/proc_control_unit_if.sv | 44 ++++
 rtl/ctrl_ir_fields.sv | 27 ++
 rtl/proc_control_unit.sv | 151 +++++++++++++++
 tb/tb_proc_control_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/proc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// proc_ctrl_pkg
// Shared types and constants for the six-instruction processor controller:
//   - state_t  : 4-bit FSM state encoding (also exported on OutState)
//   - OP_*     : instruction opcodes carried in IR[15:12]
//   - ALU_*    : ALU operation select codes driven on ALU_s0
// ---------------------------------------------------------------------------
package proc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_NOOP      = 4'd3,
        S_LOAD_A    = 4'd4,
        S_LOAD_B    = 4'd5,
        S_STORE     = 4'd6,
        S_ADD       = 4'd7,
        S_SUB       = 4'd8,
        S_HALT      = 4'd9,
        S_STEP_WAIT = 4'd10
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/proc_control_unit_if.sv
// ---------------------------------------------------------------------------
// proc_control_unit_if
// Bundles the controller's instruction input and all datapath control lines.
//   master : the controller (consumes IR/Step, drives every control)
//   slave  : the PC / IR / RAM / register file / ALU side
// Optional macro CTRL_STEP_EN adds the single-step input Step.
// ---------------------------------------------------------------------------
interface proc_control_unit_if;
    logic [15:0] IR;
`ifdef CTRL_STEP_EN
    logic        Step;
`endif
    logic        PC_clr;
    logic        PC_up;
    logic        IR_ld;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  OutState;
    logic        Halted;

    modport master (
        input  IR,
`ifdef CTRL_STEP_EN
        input  Step,
`endif
        output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState, Halted
    );

    modport slave (
        output IR,
`ifdef CTRL_STEP_EN
        output Step,
`endif
        input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState, Halted
    );
endinterface

// File: rtl/ctrl_ir_fields.sv
// ---------------------------------------------------------------------------
// ctrl_ir_fields
// Purely combinational split of the 16-bit instruction word.
//   ir      in  16  instruction register
//   opcode  out 4   IR[15:12]
//   ra      out 4   IR[11:8]  (STORE source, ADD/SUB operand A)
//   rb      out 4   IR[7:4]   (ADD/SUB operand B)
//   rw      out 4   IR[3:0]   (LOAD/ADD/SUB destination)
//   ld_addr out 8   IR[11:4]  (LOAD memory address)
//   st_addr out 8   IR[7:0]   (STORE memory address)
// ---------------------------------------------------------------------------
module ctrl_ir_fields (
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [3:0]  rw,
    output logic [7:0]  ld_addr,
    output logic [7:0]  st_addr
);
    assign opcode  = ir[15:12];
    assign ra      = ir[11:8];
    assign rb      = ir[7:4];
    assign rw      = ir[3:0];
    assign ld_addr = ir[11:4];
    assign st_addr = ir[7:0];
endmodule

// File: rtl/proc_control_unit.sv
// ---------------------------------------------------------------------------
// proc_control_unit
// Moore FSM controller for the six-instruction processor. Clears/increments
// the PC, loads the IR, decodes IR[15:12] and sequences RAM, register file
// and ALU controls.
// Ports:
//   Clk    in  system clock, rising edge
//   Reset  in  asynchronous active-high reset (forces INIT)
//   bus    master modport of proc_control_unit_if (IR in, all controls out)
// Parameters:
//   HALT_ON_ILLEGAL  1: opcodes 6..15 halt, 0: they execute as NOOP
//   INIT_CYCLES      cycles spent in INIT with PC_clr high (1..15)
// Optional macro CTRL_STEP_EN: adds bus.Step; completed instructions park in
// STEP_WAIT until Step is seen high.
// ---------------------------------------------------------------------------
module proc_control_unit
    import proc_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int INIT_CYCLES     = 1
) (
    input  logic               Clk,
    input  logic               Reset,
    proc_control_unit_if.master bus
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    // Where an executed instruction goes once it is done.
`ifdef CTRL_STEP_EN
    localparam state_t AFTER_EXEC = S_STEP_WAIT;
`else
    localparam state_t AFTER_EXEC = S_FETCH;
`endif

    state_t      state_reg, state_next;
    logic [3:0]  init_cnt_reg, init_cnt_next;

    logic [3:0]  opcode, ra, rb, rw;
    logic [7:0]  ld_addr, st_addr;

    ctrl_ir_fields u_fields (
        .ir      (bus.IR),
        .opcode  (opcode),
        .ra      (ra),
        .rb      (rb),
        .rw      (rw),
        .ld_addr (ld_addr),
        .st_addr (st_addr)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= S_INIT;
            init_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = 8'd0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = 4'd0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = 4'd0;
        bus.RF_Rb_addr = 4'd0;
        bus.ALU_s0     = ALU_PASS;
        bus.Halted     = 1'b0;
        bus.OutState   = state_reg;

        case (state_reg)
            S_INIT: begin
                bus.PC_clr = 1'b1;
                if (init_cnt_reg >= INIT_LAST) begin
                    state_next    = S_FETCH;
                    init_cnt_next = 4'd0;
                end else begin
                    init_cnt_next = init_cnt_reg + 4'd1;
                end
            end
            S_FETCH: begin
                // IR captures mem[PC] on the same edge the PC advances.
                bus.IR_ld  = 1'b1;
                bus.PC_up  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_next = S_NOOP;
                    OP_STORE: state_next = S_STORE;
                    OP_LOAD:  state_next = S_LOAD_A;
                    OP_ADD:   state_next = S_ADD;
                    OP_SUB:   state_next = S_SUB;
                    OP_HALT:  state_next = S_HALT;
                    default:  state_next = HALT_ON_ILLEGAL ? S_HALT : S_NOOP;
                endcase
            end
            S_NOOP: begin
                state_next = AFTER_EXEC;
            end
            S_LOAD_A: begin
                // Address presented one cycle early to cover the RAM read latency.
                bus.D_addr    = ld_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = rw;
                state_next    = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.D_addr    = ld_addr;
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = rw;
                bus.RF_W_en   = 1'b1;
                state_next    = AFTER_EXEC;
            end
            S_STORE: begin
                bus.D_addr     = st_addr;
                bus.RF_Ra_addr = ra;
                bus.D_wr       = 1'b1;
                state_next     = AFTER_EXEC;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = ra;
                bus.RF_Rb_addr = rb;
                bus.RF_W_addr  = rw;
                bus.ALU_s0     = (state_reg == S_ADD) ? ALU_ADD : ALU_SUB;
                bus.RF_W_en    = 1'b1;
                state_next     = AFTER_EXEC;
            end
            S_HALT: begin
                bus.Halted = 1'b1;
            end
`ifdef CTRL_STEP_EN
            S_STEP_WAIT: begin
                if (bus.Step) state_next = S_FETCH;
            end
`endif
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_unit.sv
module tb_proc_control_unit;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] w_addr;
        logic       w_en;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic [3:0] st;
        logic       halted;
    } ctl_t;

`ifdef CTRL_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    proc_control_unit_if bus_a();
    proc_control_unit_if bus_b();

    proc_control_unit #(.HALT_ON_ILLEGAL(1'b1), .INIT_CYCLES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a));
    proc_control_unit #(.HALT_ON_ILLEGAL(1'b0), .INIT_CYCLES(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b));

    int   checks = 0;
    int   failures = 0;
    bit   sel = 1'b0;          // 0: observe/drive dut_a, 1: dut_b
    int   init_cur = 2;
    bit   halt_ill_cur = 1'b1;

    ctl_t obs_a, obs_b, obs;
    assign obs_a = '{pc_clr: bus_a.PC_clr, pc_up: bus_a.PC_up, ir_ld: bus_a.IR_ld,
                     d_addr: bus_a.D_addr, d_wr: bus_a.D_wr, rf_s: bus_a.RF_s,
                     w_addr: bus_a.RF_W_addr, w_en: bus_a.RF_W_en, ra: bus_a.RF_Ra_addr,
                     rb: bus_a.RF_Rb_addr, alu: bus_a.ALU_s0, st: bus_a.OutState,
                     halted: bus_a.Halted};
    assign obs_b = '{pc_clr: bus_b.PC_clr, pc_up: bus_b.PC_up, ir_ld: bus_b.IR_ld,
                     d_addr: bus_b.D_addr, d_wr: bus_b.D_wr, rf_s: bus_b.RF_s,
                     w_addr: bus_b.RF_W_addr, w_en: bus_b.RF_W_en, ra: bus_b.RF_Ra_addr,
                     rb: bus_b.RF_Rb_addr, alu: bus_b.ALU_s0, st: bus_b.OutState,
                     halted: bus_b.Halted};
    assign obs = sel ? obs_b : obs_a;

    // Reference: control outputs the specification lists for a given state
    // number and instruction word.
    function automatic ctl_t model(input int st, input logic [15:0] ir);
        ctl_t e = '0;
        e.st = 4'(st);
        case (st)
            0: e.pc_clr = 1'b1;
            1: begin e.ir_ld = 1'b1; e.pc_up = 1'b1; end
            4, 5: begin
                e.d_addr = ir[11:4]; e.rf_s = 1'b1; e.w_addr = ir[3:0];
                e.w_en = (st == 5);
            end
            6: begin e.d_addr = ir[7:0]; e.ra = ir[11:8]; e.d_wr = 1'b1; end
            7, 8: begin
                e.ra = ir[11:8]; e.rb = ir[7:4]; e.w_addr = ir[3:0]; e.w_en = 1'b1;
                e.alu = (st == 7) ? 3'b001 : 3'b010;
            end
            9: e.halted = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (state obs=%0d exp=%0d)",
                   tag, obs, exp, obs.st, exp.st);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ir(input logic [15:0] ir);
        if (sel) bus_b.IR = ir; else bus_a.IR = ir;
    endtask

    // Reset is already pending or just applied; check INIT then the release.
    task automatic reset_seq(input string tag);
        Reset = 1'b1;
        #1;
        check({tag, "_rst_async"}, model(0, 16'h0));
        tick();
        check({tag, "_rst_held"}, model(0, 16'h0));
        Reset = 1'b0;
        for (int k = 1; k < init_cur; k++) begin
            tick();
            check({tag, "_init"}, model(0, 16'h0));
        end
        $display("reset %s init_cycles=%0d", tag, init_cur);
    endtask

    // One whole instruction from FETCH to its last state, checked cycle by cycle.
    task automatic run_instr(input string tag, input logic [15:0] ir);
        int q[$];
        int pcup = 0;
        bit halts;
        logic [3:0] op = ir[15:12];
        q.push_back(1);
        q.push_back(2);
        case (op)
            4'd0: q.push_back(3);
            4'd1: q.push_back(6);
            4'd2: begin q.push_back(4); q.push_back(5); end
            4'd3: q.push_back(7);
            4'd4: q.push_back(8);
            4'd5: q.push_back(9);
            default: q.push_back(halt_ill_cur ? 9 : 3);
        endcase
        halts = (q[q.size()-1] == 9);
        if (!halts && STEP) q.push_back(10);
        foreach (q[i]) begin
            tick();
            if (i == 1) set_ir(ir);
            check(tag, model(q[i], ir));
            pcup += int'(obs.pc_up);
        end
        if (halts) begin
            for (int k = 0; k < 20; k++) begin
                tick();
                check({tag, "_halt_hold"}, model(9, ir));
                pcup += int'(obs.pc_up);
            end
        end
        checks++;
        assert (pcup == 1) else begin
            failures++;
            $error("FAIL %s_pc_up_count observed=%0d expected=1", tag, pcup);
        end
        $display("instr %s dut=%0d ir=%h cycles=%0d", tag, sel, ir, q.size());
    endtask

    initial begin
        logic [15:0] rir;
        int unsigned op;
        bus_a.IR = 16'h0;
        bus_b.IR = 16'h0;
`ifdef CTRL_STEP_EN
        bus_a.Step = 1'b1;
        bus_b.Step = 1'b1;
`endif
        #2;

        // ---- dut_a: HALT_ON_ILLEGAL=1, INIT_CYCLES=2 ----
        sel = 1'b0; init_cur = 2; halt_ill_cur = 1'b1;
        reset_seq("a_power_on");
        run_instr("load_2C35", 16'h2C35);
        run_instr("add_3124", 16'h3124);
        run_instr("sub_4124", 16'h4124);
        run_instr("store_15A0", 16'h15A0);
        run_instr("noop_0000", 16'h0000);

        // Reset in the middle of an ADD
        tick(); check("madd_fetch", model(1, 16'h0));
        tick(); set_ir(16'h3124); check("madd_decode", model(2, 16'h3124));
        tick(); check("madd_add", model(7, 16'h3124));
        #2;
        reset_seq("a_mid_add");

        for (int n = 0; n < 30; n++) begin
            op  = $urandom_range(0, 4);
            rir = {op[3:0], 12'($urandom_range(0, 4095))};
            run_instr("rand_a", rir);
        end

`ifdef CTRL_STEP_EN
        // Step held low after a NOOP parks the FSM in STEP_WAIT
        bus_a.Step = 1'b0;
        tick(); check("step_fetch", model(1, 16'h0));
        tick(); set_ir(16'h0000); check("step_decode", model(2, 16'h0));
        tick(); check("step_noop", model(3, 16'h0));
        for (int k = 0; k < 5; k++) begin
            tick(); check("step_wait", model(10, 16'h0));
        end
        bus_a.Step = 1'b1;
        tick();
        bus_a.Step = 1'b0;
        check("step_pulse_fetch", model(1, 16'h0));
        bus_a.Step = 1'b1;
        tick(); check("step_decode2", model(2, 16'h0));
        tick(); check("step_noop2", model(3, 16'h0));
        tick(); check("step_wait2", model(10, 16'h0));
        $display("step single-step sequence done");
`endif

        run_instr("halt_5000", 16'h5000);
        reset_seq("a_after_halt");
        run_instr("illegal_F000_halts", 16'hF000);

        // ---- dut_b: HALT_ON_ILLEGAL=0, INIT_CYCLES=1 ----
        sel = 1'b1; init_cur = 1; halt_ill_cur = 1'b0;
        reset_seq("b_reset");
        run_instr("illegal_F000_noop", 16'hF000);
        run_instr("illegal_6ABC_noop", 16'h6ABC);
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 14);
            if (op >= 5) op = op + 1;   // skip HALT inside the random stream
            rir = {op[3:0], 12'($urandom_range(0, 4095))};
            run_instr("rand_b", rir);
        end
        run_instr("halt_b_5000", 16'h5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
